// File: rtl/divider_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 8;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, restore on borrow.
module divider_step
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;

    // The partial remainder is always below the divisor, so the kept result fits in WIDTH bits.
    always_comb begin
        shifted = {rem_in, bit_in};
        q_bit   = (shifted >= {1'b0, divisor});
        rem_out = q_bit ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/divider_8bit_seq.sv
// Iterative restoring divider, one quotient bit per clock with start/done handshake.
// Define DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
//
// state | meaning
// IDLE  | waiting for start
// RUN   | iterating, cnt steps 0..WIDTH-1
// DONE  | result valid, done pulses for this cycle
module divider_8bit_seq
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    div_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] prem_r;
    logic [WIDTH-1:0] prem_nxt;
    logic             q_bit;
    logic [WIDTH-1:0] q_raw;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    assign busy  = (state == RUN);
    assign q_raw = {dvd_r[WIDTH-2:0], q_bit};

`ifdef DIVIDER_SIGNED_EN
    logic neg_q;
    logic neg_r;

    assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign q_final = neg_q ? -q_raw    : q_raw;
    assign r_final = neg_r ? -prem_nxt : prem_nxt;

    // Signs captured alongside the magnitudes; the remainder follows the dividend.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (start && !busy && divisor != '0) begin
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
        end
    end
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
    assign q_final = q_raw;
    assign r_final = prem_nxt;
`endif

    divider_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (prem_r),
        .bit_in  (dvd_r[WIDTH-1]),
        .divisor (dvs_r),
        .rem_out (prem_nxt),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            dvd_r       <= '0;
            dvs_r       <= '0;
            prem_r      <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            dvd_r  <= dvd_mag;
                            dvs_r  <= dvs_mag;
                            prem_r <= '0;
                            cnt    <= '0;
                            state  <= RUN;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // Quotient bits fill dvd_r from the LSB as dividend bits leave the MSB.
                    dvd_r  <= q_raw;
                    prem_r <= prem_nxt;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        quotient    <= q_final;
                        remainder   <= r_final;
                        div_by_zero <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_8bit_seq.sv
// Directed self-checking bench for divider_8bit_seq.
module tb_divider_8bit_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int nvec = 0;
    int nerr = 0;
    int lat;
    int bcnt;
    int npulse;

    divider_8bit_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Applies start for one edge; returns in cycle T+1.
    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Counts cycles (relative to T) until done, with a bound.
    task automatic wait_done(input int first, output int l, output int bc);
        l  = first;
        bc = 0;
        while (!done && l < 24) begin
            if (busy) bc++;
            tick();
            l++;
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] q, input logic [7:0] r,
                                input logic z);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_q"}, quotient, q);
        chk({tag, "_r"}, remainder, r);
        chk({tag, "_dbz"}, div_by_zero, z);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        tick();
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_q", quotient, 8'd0);
        chk("rst_r", remainder, 8'd0);
        chk("rst_dbz", div_by_zero, 1'b0);
        rst = 1'b0;
        tick();

        // 200 / 7
        launch(8'd200, 8'd7);
        wait_done(1, lat, bcnt);
        chk("u200_7_lat", lat, 9);
        chk("u200_7_busy", bcnt, 8);
        check_result("u200_7", 8'd28, 8'd4, 1'b0);
        tick();
        chk("u200_7_pulse", done, 1'b0);
        chk("u200_7_hold", quotient, 8'd28);

        // 13 / 0
        launch(8'd13, 8'd0);
        chk("dz_busy", busy, 1'b0);
        wait_done(1, lat, bcnt);
        chk("dz_lat", lat, 1);
        check_result("dz", 8'hFF, 8'd13, 1'b1);
        tick();

        // 255 / 1 then back-to-back 9 / 3 issued in the DONE cycle
        launch(8'd255, 8'd1);
        wait_done(1, lat, bcnt);
        chk("b2b1_lat", lat, 9);
        check_result("b2b1", 8'd255, 8'd0, 1'b0);
        launch(8'd9, 8'd3);
        wait_done(1, lat, bcnt);
        chk("b2b2_lat", lat, 9);
        check_result("b2b2", 8'd3, 8'd0, 1'b0);
        tick();

        // start during RUN is ignored
        launch(8'd50, 8'd5);
        tick();
        tick();
        dividend = 8'd99;
        divisor  = 8'd2;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_done(4, lat, bcnt);
        chk("ign_lat", lat, 9);
        check_result("ign", 8'd10, 8'd0, 1'b0);
        npulse = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) npulse++;
        end
        chk("ign_extra_done", npulse, 0);
        chk("ign_idle_busy", busy, 1'b0);

        // reset mid-RUN
        launch(8'd200, 8'd7);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_q", quotient, 8'd0);
        chk("abort_r", remainder, 8'd0);
        chk("abort_dbz", div_by_zero, 1'b0);
        npulse = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) npulse++;
        end
        chk("abort_no_done", npulse, 0);
        launch(8'd100, 8'd10);
        wait_done(1, lat, bcnt);
        chk("post_abort_lat", lat, 9);
        check_result("post_abort", 8'd10, 8'd0, 1'b0);
        tick();

`ifdef DIVIDER_SIGNED_EN
        launch(8'hF9, 8'd2);
        wait_done(1, lat, bcnt);
        check_result("s_m7_2", 8'hFD, 8'hFF, 1'b0);
        tick();
        launch(8'd7, 8'hFE);
        wait_done(1, lat, bcnt);
        check_result("s_7_m2", 8'hFD, 8'd1, 1'b0);
        tick();
        launch(8'h80, 8'hFF);
        wait_done(1, lat, bcnt);
        chk("s_wrap_lat", lat, 9);
        check_result("s_wrap", 8'h80, 8'd0, 1'b0);
        tick();
        launch(8'hF3, 8'd0);
        wait_done(1, lat, bcnt);
        check_result("s_dz", 8'hFF, 8'hF3, 1'b1);
        tick();
`else
        launch(8'd255, 8'd255);
        wait_done(1, lat, bcnt);
        check_result("u255_255", 8'd1, 8'd0, 1'b0);
        tick();
        launch(8'd7, 8'd200);
        wait_done(1, lat, bcnt);
        check_result("u7_200", 8'd0, 8'd7, 1'b0);
        tick();
        launch(8'd0, 8'd5);
        wait_done(1, lat, bcnt);
        check_result("u0_5", 8'd0, 8'd0, 1'b0);
        tick();
        launch(8'd254, 8'd128);
        wait_done(1, lat, bcnt);
        check_result("u254_128", 8'd1, 8'd126, 1'b0);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
